pattern_step_gen: RTL

PATTERN_STEP_GEN -- requirements
Module: pattern_step_gen

---
 rtl/pattern_step_gen.sv | 99 +++++++++
 1 files changed

// File: rtl/pattern_step_gen.sv
// Step-index generator feeding a 7-segment pattern decoder: a prescaled or
// single-stepped tick advances a 3-bit index in up/down/ping-pong/LFSR order.
module pattern_step_gen #(
    parameter int SHIFT = 2
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_enable,
    input  logic       i_step,
    input  logic [1:0] i_mode,
    input  logic [2:0] i_speed,
    output logic [2:0] o_count,
    output logic       o_tick,
    output logic       o_dir
);

    localparam int PW = SHIFT + 3;

    typedef enum logic [1:0] {
        MODE_UP   = 2'd0,
        MODE_DOWN = 2'd1,
        MODE_PING = 2'd2,
        MODE_RAND = 2'd3
    } mode_e;

    logic [PW-1:0] presc_q, presc_d;
    logic [2:0]    count_q, count_d;
    logic          tick_q, tick_d;
    logic          dir_q, dir_d;
    logic [7:0]    lfsr_q, lfsr_d;

    logic [3:0]    mult;
    logic [PW:0]   period, period_m1;
    logic          free_step, man_step, step;
    logic [2:0]    pp_next;
    logic [7:0]    lfsr_adv;

    always_comb begin
        mult      = 4'd8 - {1'b0, i_speed};
        period    = (PW+1)'(mult) << SHIFT;
        period_m1 = period - (PW+1)'(1);

        // >= rather than == so a speed increase never forces a full wrap
        free_step = i_enable && ({1'b0, presc_q} >= period_m1);
        man_step  = !i_enable && i_step;
        step      = free_step || man_step;

        pp_next  = dir_q ? (count_q - 3'd1) : (count_q + 3'd1);
        lfsr_adv = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

        presc_d = presc_q;
        count_d = count_q;
        dir_d   = dir_q;
        lfsr_d  = lfsr_q;
        tick_d  = step;

        if (i_enable) begin
            presc_d = free_step ? '0 : presc_q + PW'(1);
        end

        if (step) begin
            unique case (mode_e'(i_mode))
                MODE_UP:   count_d = count_q + 3'd1;
                MODE_DOWN: count_d = count_q - 3'd1;
                MODE_PING: begin
                    count_d = pp_next;
                    if (pp_next == 3'd7)      dir_d = 1'b1;
                    else if (pp_next == 3'd0) dir_d = 1'b0;
                end
                MODE_RAND: begin
                    lfsr_d  = lfsr_adv;
                    count_d = lfsr_adv[2:0];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            presc_q <= '0;
            count_q <= 3'd0;
            tick_q  <= 1'b0;
            dir_q   <= 1'b0;
            lfsr_q  <= 8'hA5;
        end else begin
            presc_q <= presc_d;
            count_q <= count_d;
            tick_q  <= tick_d;
            dir_q   <= dir_d;
            lfsr_q  <= lfsr_d;
        end
    end

    assign o_count = count_q;
    assign o_tick  = tick_q;
    assign o_dir   = dir_q;

endmodule
